// File: rtl/ysyx_22040895_div_pkg.sv
// Shared definitions for the iterative RV64M divide unit: FSM state
// encodings and the per-width iteration counts.
package ysyx_22040895_div_pkg;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    localparam int ITER_WORD  = 32;
    localparam int ITER_DWORD = 64;

endpackage

// File: rtl/ysyx_22040895_div.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU and their W forms.
// One quotient bit per clock; results held until the consumer accepts them.
module ysyx_22040895_div
    import ysyx_22040895_div_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic            signed_i,
    input  logic            wordop_i,
    input  logic [XLEN-1:0] dividend_i,
    input  logic [XLEN-1:0] divisor_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] quotient_o,
    output logic [XLEN-1:0] remainder_o
);

    div_state_e state_reg, state_next;

    logic [CNT_W-1:0] cnt_reg;
    logic [XLEN-1:0]  rem_reg, quo_reg, divisor_reg;
    logic             neg_quo_reg, neg_rem_reg, wordop_reg;
    logic [XLEN-1:0]  quotient_reg, remainder_reg;

    // Operand narrowing and magnitude preparation
    logic [XLEN-1:0] dividend_n, divisor_n, dividend_abs, divisor_abs;
    logic            dividend_neg, divisor_neg, div_zero, overflow, early, accept;
    logic [XLEN-1:0] early_q, early_r, early_q_w, early_r_w, quo_init;

    assign dividend_n = wordop_i ? {{(XLEN-32){signed_i & dividend_i[31]}}, dividend_i[31:0]}
                                 : dividend_i;
    assign divisor_n  = wordop_i ? {{(XLEN-32){signed_i & divisor_i[31]}}, divisor_i[31:0]}
                                 : divisor_i;

    assign dividend_neg = signed_i & dividend_n[XLEN-1];
    assign divisor_neg  = signed_i & divisor_n[XLEN-1];
    assign dividend_abs = dividend_neg ? -dividend_n : dividend_n;
    assign divisor_abs  = divisor_neg  ? -divisor_n  : divisor_n;

    assign div_zero = (divisor_n == '0);
    assign overflow = signed_i & (wordop_i
        ? (dividend_i[31:0] == 32'h8000_0000) && (divisor_i[31:0] == 32'hFFFF_FFFF)
        : (dividend_i == {1'b1, {(XLEN-1){1'b0}}}) && (&divisor_i));
    assign early  = div_zero | overflow;
    assign accept = in_valid_i & in_ready_o & ~flush_i;

    assign early_q   = div_zero ? '1 : dividend_n;
    assign early_r   = div_zero ? dividend_n : '0;
    assign early_q_w = wordop_i ? {{(XLEN-32){early_q[31]}}, early_q[31:0]} : early_q;
    assign early_r_w = wordop_i ? {{(XLEN-32){early_r[31]}}, early_r[31:0]} : early_r;

    // W ops park the 32 dividend bits at the top so 32 shifts consume them all
    assign quo_init = wordop_i ? {dividend_abs[31:0], {(XLEN-32){1'b0}}} : dividend_abs;

    // One restoring step: shift {rem, quo} left, trial-subtract the divisor
    logic [XLEN:0]   shifted, diff;
    logic            no_borrow;
    logic [XLEN-1:0] rem_step, quo_step, q_fix, r_fix, q_final, r_final;

    assign shifted   = {rem_reg, quo_reg[XLEN-1]};
    assign diff      = shifted - {1'b0, divisor_reg};
    assign no_borrow = ~diff[XLEN];
    assign rem_step  = no_borrow ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    assign quo_step  = {quo_reg[XLEN-2:0], no_borrow};

    assign q_fix   = neg_quo_reg ? -quo_step : quo_step;
    assign r_fix   = neg_rem_reg ? -rem_step : rem_step;
    assign q_final = wordop_reg ? {{(XLEN-32){q_fix[31]}}, q_fix[31:0]} : q_fix;
    assign r_final = wordop_reg ? {{(XLEN-32){r_fix[31]}}, r_fix[31:0]} : r_fix;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            DIV_IDLE: if (accept) state_next = early ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: if (cnt_reg == CNT_W'(1)) state_next = DIV_DONE;
            DIV_DONE: if (out_ready_i) state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
        if (flush_i) state_next = DIV_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= DIV_IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            divisor_reg   <= '0;
            neg_quo_reg   <= 1'b0;
            neg_rem_reg   <= 1'b0;
            wordop_reg    <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                if (early) begin
                    quotient_reg  <= early_q_w;
                    remainder_reg <= early_r_w;
                end else begin
                    rem_reg     <= '0;
                    quo_reg     <= quo_init;
                    divisor_reg <= divisor_abs;
                    neg_quo_reg <= dividend_neg ^ divisor_neg;
                    neg_rem_reg <= dividend_neg;
                    wordop_reg  <= wordop_i;
                    cnt_reg     <= wordop_i ? CNT_W'(ITER_WORD) : CNT_W'(ITER_DWORD);
                end
            end else if (state_reg == DIV_BUSY && !flush_i) begin
                rem_reg <= rem_step;
                quo_reg <= quo_step;
                cnt_reg <= cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    quotient_reg  <= q_final;
                    remainder_reg <= r_final;
                end
            end
        end
    end

    assign in_ready_o  = (state_reg == DIV_IDLE);
    assign out_valid_o = (state_reg == DIV_DONE);
    assign quotient_o  = quotient_reg;
    assign remainder_o = remainder_reg;

endmodule

// File: tb/tb_ysyx_22040895_div.sv
// Self-checking bench for the iterative divider: directed vectors, a reference
// model for random operations, backpressure, flush and asynchronous reset.
module tb_ysyx_22040895_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, signed_op, wordop, flush, out_valid, out_ready;
    logic [63:0] dividend, divisor, quotient, remainder;

    typedef struct {
        logic [63:0] q;
        logic [63:0] r;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    ysyx_22040895_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .signed_i    (signed_op),
        .wordop_i    (wordop),
        .dividend_i  (dividend),
        .divisor_i   (divisor),
        .flush_i     (flush),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .quotient_o  (quotient),
        .remainder_o (remainder)
    );

    always #5 clk = ~clk;

    // Reference: RISC-V divide semantics written in terms of SV arithmetic
    function automatic exp_t model(input logic s, input logic w,
                                   input logic [63:0] a, input logic [63:0] b);
        exp_t        e;
        logic [63:0] an, bn;
        an = w ? (s ? {{32{a[31]}}, a[31:0]} : {32'd0, a[31:0]}) : a;
        bn = w ? (s ? {{32{b[31]}}, b[31:0]} : {32'd0, b[31:0]}) : b;
        e.lat = w ? 32 : 64;
        if (bn == 64'd0) begin
            e.q = '1; e.r = an; e.lat = 0;
        end else if (s && an == 64'h8000_0000_0000_0000 && bn == '1) begin
            e.q = an; e.r = 64'd0; e.lat = 0;
        end else if (s) begin
            e.q = $signed(an) / $signed(bn);
            e.r = $signed(an) % $signed(bn);
            if (w && an == 64'hFFFF_FFFF_8000_0000 && bn == '1) e.lat = 0;
        end else begin
            e.q = an / bn;
            e.r = an % bn;
        end
        if (w) begin
            e.q = {{32{e.q[31]}}, e.q[31:0]};
            e.r = {{32{e.r[31]}}, e.r[31:0]};
        end
        return e;
    endfunction

    // Presents one request for a single cycle; called #1 after a clock edge
    task automatic start(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b);
        signed_op = s; wordop = w; dividend = a; divisor = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Runs one request to completion and returns what the unit produced
    task automatic issue(input logic s, input logic w, input logic [63:0] a, input logic [63:0] b,
                         output int lat, output logic [63:0] q, output logic [63:0] r, output bit ok);
        start(s, w, a, b);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        ok = out_valid;
        q = quotient;
        r = remainder;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        $display("op s=%0b w=%0b a=%h b=%h -> q=%h r=%h lat=%0d", s, w, a, b, q, r, lat);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_cmp++; if (quotient !== 64'd0) begin n_err++; $display("FAIL reset_quotient got %h want 0", quotient); end
        n_cmp++; if (remainder !== 64'd0) begin n_err++; $display("FAIL reset_remainder got %h want 0", remainder); end
    endtask

    task automatic test_directed();
        logic        s_t[7]  = '{1, 0, 1, 1, 0, 1, 0};
        logic        w_t[7]  = '{0, 0, 0, 1, 1, 1, 0};
        logic [63:0] a_t[7]  = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd5, 64'h8000_0000_0000_0000,
                                 64'h0000_0000_8000_0000, 64'h0000_0001_8000_0000, 64'd7, 64'd100};
        logic [63:0] b_t[7]  = '{64'd2, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd7};
        logic [63:0] q_t[7]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
                                 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd14};
        logic [63:0] r_t[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd0, 64'd0, 64'd0, 64'd1, 64'd2};
        int          l_t[7]  = '{64, 0, 0, 0, 32, 32, 64};
        int          lat;
        logic [63:0] q, r;
        bit          ok;
        exp_t        e;
        for (int i = 0; i < 7; i++) begin
            sb.push_back('{q: q_t[i], r: r_t[i], lat: l_t[i]});
            issue(s_t[i], w_t[i], a_t[i], b_t[i], lat, q, r, ok);
            e = sb.pop_front();
            n_cmp++; if (!ok) begin n_err++; $display("FAIL dir%0d_timeout no out_valid within 200 cycles", i); end
            n_cmp++; if (q !== e.q) begin n_err++; $display("FAIL dir%0d_quotient got %h want %h", i, q, e.q); end
            n_cmp++; if (r !== e.r) begin n_err++; $display("FAIL dir%0d_remainder got %h want %h", i, r, e.r); end
            n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_random();
        logic        s, w;
        logic [63:0] a, b, q, r;
        int          lat;
        bit          ok;
        exp_t        e;
        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       b = 64'd0;
                1:       b = 64'($urandom_range(1, 50));
                2:       b = {32'hFFFF_FFFF, $urandom};
                default: b = {$urandom, $urandom};
            endcase
            sb.push_back(model(s, w, a, b));
            issue(s, w, a, b, lat, q, r, ok);
            e = sb.pop_front();
            n_cmp++; if (!ok) begin n_err++; $display("FAIL rnd%0d_timeout no out_valid within 200 cycles", i); end
            n_cmp++; if (q !== e.q) begin n_err++; $display("FAIL rnd%0d_quotient got %h want %h", i, q, e.q); end
            n_cmp++; if (r !== e.r) begin n_err++; $display("FAIL rnd%0d_remainder got %h want %h", i, r, e.r); end
            n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_backpressure();
        int   cyc = 0;
        exp_t e;
        sb.push_back('{q: 64'd14, r: 64'd2, lat: 32});
        start(1'b1, 1'b1, 64'd100, 64'd7);
        while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        e = sb.pop_front();
        n_cmp++; if (cyc !== e.lat) begin n_err++; $display("FAIL bp_latency got %0d want %0d", cyc, e.lat); end
        signed_op = 1'b0; wordop = 1'b0; dividend = 64'd9; divisor = 64'd3; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_hold%0d_valid got %b want 1", i, out_valid); end
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_hold%0d_ready got %b want 0", i, in_ready); end
            n_cmp++; if (quotient !== e.q || remainder !== e.r)
                begin n_err++; $display("FAIL bp_hold%0d_data got %h/%h want %h/%h", i, quotient, remainder, e.q, e.r); end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_err++; $display("FAIL bp_release got valid=%b ready=%b want 0/1", out_valid, in_ready); end
        $display("backpressure held 5 cycles q=%h r=%h", e.q, e.r);
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        start(1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
            begin n_err++; $display("FAIL flush_idle got ready=%b valid=%b want 1/0", in_ready, out_valid); end
        for (int i = 0; i < 70; i++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_quiet got activity=%b want 0", seen); end
        $display("flush at busy step 10 discarded operation");
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        start(1'b1, 1'b0, 64'd12345, 64'd17);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 64'd0)
            begin n_err++; $display("FAIL rst_mid got ready=%b valid=%b q=%h want 1/0/0", in_ready, out_valid, quotient); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (out_valid || !in_ready) seen = 1'b1;
            @(posedge clk); #1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rst_quiet got activity=%b want 0", seen); end
        $display("reset mid-busy discarded operation");
    endtask

    task automatic test_after_abort();
        int          lat;
        logic [63:0] q, r;
        bit          ok;
        exp_t        e;
        sb.push_back('{q: 64'd14, r: 64'd2, lat: 64});
        issue(1'b0, 1'b0, 64'd100, 64'd7, lat, q, r, ok);
        e = sb.pop_front();
        n_cmp++; if (!ok) begin n_err++; $display("FAIL post_abort_timeout no out_valid within 200 cycles"); end
        n_cmp++; if (q !== e.q || r !== e.r) begin n_err++; $display("FAIL post_abort_data got %h/%h want %h/%h", q, r, e.q, e.r); end
        n_cmp++; if (lat !== e.lat) begin n_err++; $display("FAIL post_abort_latency got %0d want %0d", lat, e.lat); end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; signed_op = 1'b0; wordop = 1'b0;
        dividend = 64'd0; divisor = 64'd0; flush = 1'b0; out_ready = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_flush();
        test_after_abort();
        test_reset_mid();
        test_after_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
